merge_arb2: RTL

MERGE_ARB2 -- requirements
Module: merge_arb2

---
 rtl/merge_arb2.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/merge_arb2.sv
// merge_arb2 -- two-input round-robin merge into a small in-order output FIFO.
//
// Two packet streams (decoder branches 0 and 1) compete for a single output.
// One input is granted per cycle: a lone valid input wins outright, and on a
// tie the input that did not win the previous transfer wins. Accepted packets
// are written to a DEPTH-entry FIFO whose head drives the output port.
//
// Parameters
//   WIDTH  packet width in bits (default 9)
//   DEPTH  FIFO entries, 2 or 4 (default 2)
//
// Ports
//   CLK        single clock, rising edge
//   RESET      synchronous, active-high reset
//   in0_data   packet from branch 0
//   in0_valid  in0_data holds a packet
//   in0_ready  in0 packet accepted this cycle
//   in1_*      same for branch 1
//   out_data   head-of-FIFO packet
//   out_valid  out_data holds a packet (FIFO not empty)
//   out_ready  downstream accepts out_data this cycle
//   out_src    input index of the head packet (MERGE_ARB2_SRC_EN only)
//
// Build option
//   MERGE_ARB2_SRC_EN  when defined, each FIFO entry also stores the winning
//                      input index and the out_src port is present.

module merge_arb2 #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_valid,
    output logic             in1_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
`ifdef MERGE_ARB2_SRC_EN
    ,
    output logic             out_src
`endif
);

    localparam int PTR_W = (DEPTH > 2) ? 2 : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

`ifdef MERGE_ARB2_SRC_EN
    localparam int ENTRY_W = WIDTH + 1;
`else
    localparam int ENTRY_W = WIDTH;
`endif

    generate
        if (DEPTH != 2 && DEPTH != 4) begin : g_bad_depth
            $error("merge_arb2: DEPTH must be 2 or 4");
        end
    endgenerate

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               last_grant;

    logic               full;
    logic               grant0;
    logic               grant1;
    logic               push;
    logic               pop;
    logic               win_idx;
    logic [WIDTH-1:0]   win_data;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head_entry;

    assign full = (count == DEPTH_C);

    // On a tie the input other than the previous winner takes the slot.
    assign grant0 = in0_valid && (!in1_valid || last_grant);
    assign grant1 = in1_valid && (!in0_valid || !last_grant);

    // RESET gates the readies directly, so neither input can be accepted
    // while reset is asserted. Full blocks pushes even when a pop happens in
    // the same cycle, so the count never has to handle pass-through.
    assign in0_ready = grant0 && !full && !RESET;
    assign in1_ready = grant1 && !full && !RESET;

    assign push = (in0_valid && in0_ready) || (in1_valid && in1_ready);
    assign pop  = out_valid && out_ready;

    assign win_idx  = in1_ready;
    assign win_data = in1_ready ? in1_data : in0_data;

`ifdef MERGE_ARB2_SRC_EN
    assign wr_entry = {win_idx, win_data};
`else
    assign wr_entry = win_data;
`endif

    assign head_entry = mem[rd_ptr];
    assign out_valid  = (count != '0);
    assign out_data   = head_entry[WIDTH-1:0];

`ifdef MERGE_ARB2_SRC_EN
    assign out_src = head_entry[WIDTH];
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            last_grant <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_entry;
                wr_ptr      <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
                last_grant  <= win_idx;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
